// File: rtl/multicycle_pkg.sv
// multicycle_pkg: states, opcode/funct/ALU constants and decode helper for the multicycle controller
package multicycle_pkg;
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXEC_R = 4'd2,
      EXEC_I = 4'd3,
      MEMADR = 4'd4,
      MEMRD  = 4'd5,
      MEMWB  = 4'd6,
      MEMWR  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      WB     = 4'd10
   } state_t;

   localparam logic [5:0] OP_R     = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ADDIU = 6'd9;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [5:0] F_ADD = 6'd32;
   localparam logic [5:0] F_SUB = 6'd34;
   localparam logic [5:0] F_SLT = 6'd42;

   localparam int ALU_AND = 0;
   localparam int ALU_ADD = 2;
   localparam int ALU_SUB = 3;
   localparam int ALU_SLT = 4;

   localparam logic [1:0] SRCB_RT  = 2'd0;
   localparam logic [1:0] SRCB_4   = 2'd1;
   localparam logic [1:0] SRCB_IMM = 2'd2;

   // State following DECODE; FETCH means the instruction is undecodable
   function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] funct, input logic en_mem);
      case (op)
         OP_R:                      return (funct == F_ADD || funct == F_SUB || funct == F_SLT) ? EXEC_R : FETCH;
         OP_ADDI, OP_ADDIU, OP_ANDI: return EXEC_I;
         OP_LW, OP_SW:              return en_mem ? MEMADR : FETCH;
         OP_BEQ, OP_BNE:            return BRANCH;
         OP_J:                      return JUMP;
         default:                   return FETCH;
      endcase
   endfunction
endpackage

// File: rtl/multicycle_controller_output_decode.sv
// mc_output_decode: Moore control decode from state and instruction fields (branch also uses zero)
module mc_output_decode
   import multicycle_pkg::*;
#(
   parameter int ALUCS_W    = 5,
   parameter int ENABLE_MEM = 1
) (
   input  state_t             state,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready_eff,
   output logic               pc_write,
   output logic               ir_write,
   output logic               iord,
   output logic               mem_rden,
   output logic               mem_wren,
   output logic               alu_src_a,
   output logic [1:0]         selscrB,
   output logic [ALUCS_W-1:0] alucs,
   output logic               flagwrite,
   output logic               regwrite,
   output logic               redges,
   output logic               memtoreg,
   output logic               branch,
   output logic               jump,
   output logic               illegal
);
   // Per-state controls; anything not named in a state stays 0, unknown encodings drive nothing
   always_comb begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      iord      = 1'b0;
      mem_rden  = 1'b0;
      mem_wren  = 1'b0;
      alu_src_a = 1'b0;
      selscrB   = SRCB_RT;
      alucs     = '0;
      flagwrite = 1'b0;
      regwrite  = 1'b0;
      redges    = 1'b0;
      memtoreg  = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      illegal   = 1'b0;
      case (state)
         FETCH: begin
            mem_rden = 1'b1;
            selscrB  = SRCB_4;
            alucs    = ALUCS_W'(ALU_ADD);
            pc_write = mem_ready_eff;
            ir_write = mem_ready_eff;
         end
         DECODE: illegal = decode_next(op, funct, ENABLE_MEM != 0) == FETCH;
         EXEC_R: begin
            alu_src_a = 1'b1;
            flagwrite = 1'b1;
            alucs     = funct == F_SUB ? ALUCS_W'(ALU_SUB) : funct == F_SLT ? ALUCS_W'(ALU_SLT) : ALUCS_W'(ALU_ADD);
         end
         EXEC_I: begin
            alu_src_a = 1'b1;
            selscrB   = SRCB_IMM;
            flagwrite = 1'b1;
            alucs     = op == OP_ANDI ? ALUCS_W'(ALU_AND) : ALUCS_W'(ALU_ADD);
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            selscrB   = SRCB_IMM;
            alucs     = ALUCS_W'(ALU_ADD);
         end
         MEMRD: begin
            iord     = 1'b1;
            mem_rden = 1'b1;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            mem_wren = 1'b1;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alucs     = ALUCS_W'(ALU_SUB);
            branch    = op == OP_BEQ ? zero : !zero;
         end
         JUMP: jump = 1'b1;
         WB: begin
            regwrite = 1'b1;
            redges   = op == OP_R;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/execute/memory/writeback sequencer with retire counter
module multicycle_controller
   import multicycle_pkg::*;
#(
   parameter int ALUCS_W       = 5,
   parameter int CNT_W         = 16,
   parameter int HAS_MEM_READY = 1,
   parameter int ENABLE_MEM    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               ir_write,
   output logic               iord,
   output logic               mem_rden,
   output logic               mem_wren,
   output logic               alu_src_a,
   output logic [1:0]         selscrB,
   output logic [ALUCS_W-1:0] alucs,
   output logic               flagwrite,
   output logic               regwrite,
   output logic               redges,
   output logic               memtoreg,
   output logic               branch,
   output logic               jump,
   output logic               illegal,
   output logic [CNT_W-1:0]   instr_count,
   output logic [3:0]         state
);
   state_t           cur;
   logic [5:0]       op_q, funct_q;
   logic [CNT_W-1:0] cnt;
   logic             rdy, retire;

   assign rdy    = HAS_MEM_READY != 0 ? mem_ready : 1'b1;
   assign retire = cur inside {WB, MEMWB, BRANCH, JUMP} || (cur == MEMWR && rdy);

   // State sequencing, operand capture in DECODE and retire counting
   always_ff @(posedge clk) begin
      if (rst) begin
         cur     <= FETCH;
         op_q    <= '0;
         funct_q <= '0;
         cnt     <= '0;
      end else begin
         case (cur)
            FETCH:          if (rdy) cur <= DECODE;
            DECODE:         cur <= decode_next(op, funct, ENABLE_MEM != 0);
            EXEC_R, EXEC_I: cur <= WB;
            MEMADR:         cur <= op_q == OP_SW ? MEMWR : MEMRD;
            MEMRD:          if (rdy) cur <= MEMWB;
            MEMWR:          if (rdy) cur <= FETCH;
            default:        cur <= FETCH;
         endcase
         if (cur == DECODE) begin
            op_q    <= op;
            funct_q <= funct;
         end
         if (retire) cnt <= cnt + 1'b1;
      end
   end

   // During reset the decoder sees an unused encoding so every control is 0
   mc_output_decode #(.ALUCS_W(ALUCS_W), .ENABLE_MEM(ENABLE_MEM)) u_dec (
      .state         (rst ? state_t'(4'd15) : cur),
      .op            (cur == DECODE ? op : op_q),
      .funct         (cur == DECODE ? funct : funct_q),
      .zero          (zero),
      .mem_ready_eff (rdy),
      .pc_write      (pc_write),
      .ir_write      (ir_write),
      .iord          (iord),
      .mem_rden      (mem_rden),
      .mem_wren      (mem_wren),
      .alu_src_a     (alu_src_a),
      .selscrB       (selscrB),
      .alucs         (alucs),
      .flagwrite     (flagwrite),
      .regwrite      (regwrite),
      .redges        (redges),
      .memtoreg      (memtoreg),
      .branch        (branch),
      .jump          (jump),
      .illegal       (illegal)
   );

   assign instr_count = rst ? '0 : cnt;
   assign state       = rst ? 4'd0 : cur;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed-step self-checking bench for multicycle_controller (CNT_W=4)
module tb_multicycle_controller;
   logic       clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b1;
   logic [5:0] op = 6'd0, funct = 6'd32;
   logic       pc_write, ir_write, iord, mem_rden, mem_wren, alu_src_a, flagwrite;
   logic       regwrite, redges, memtoreg, branch, jump, illegal;
   logic [1:0] selscrB;
   logic [4:0] alucs;
   logic [3:0] instr_count, state;
   int         checks = 0, errors = 0;

   multicycle_controller #(.ALUCS_W(5), .CNT_W(4), .HAS_MEM_READY(1), .ENABLE_MEM(1)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_rden(mem_rden),
      .mem_wren(mem_wren), .alu_src_a(alu_src_a), .selscrB(selscrB), .alucs(alucs),
      .flagwrite(flagwrite), .regwrite(regwrite), .redges(redges), .memtoreg(memtoreg),
      .branch(branch), .jump(jump), .illegal(illegal), .instr_count(instr_count), .state(state)
   );

   always #5 clk = ~clk;

   wire [27:0] all_outs = {pc_write, ir_write, iord, mem_rden, mem_wren, alu_src_a, selscrB, alucs,
                           flagwrite, regwrite, redges, memtoreg, branch, jump, illegal, instr_count, state};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      tick();
      check("rst_outs0", 32'(all_outs), 0);
      tick();
      check("rst_outs1", 32'(all_outs), 0);
      rst = 1'b0;
      #1;
      check("rel_state", 32'(state), 0);
      check("rel_rden", 32'(mem_rden), 1);
      check("rel_pcw", 32'({pc_write, ir_write, selscrB, alucs}), {2'b11, 2'd1, 5'd2});
      // R-type ADD
      tick();
      check("radd_dec", 32'(state), 1);
      tick();
      check("radd_ex", 32'({state, alucs, flagwrite, alu_src_a, selscrB}), {4'd2, 5'd2, 1'b1, 1'b1, 2'd0});
      tick();
      check("radd_wb", 32'({state, regwrite, redges, memtoreg, mem_wren}), {4'd10, 4'b1100});
      tick();
      check("radd_ret", 32'({state, instr_count}), {4'd0, 4'd1});
      // LW with two wait cycles in MEMRD
      op = 6'd35;
      tick();
      check("lw_dec", 32'(state), 1);
      tick();
      check("lw_adr", 32'({state, alu_src_a, selscrB, alucs, flagwrite}), {4'd4, 1'b1, 2'd2, 5'd2, 1'b0});
      mem_ready = 1'b0;
      tick();
      check("lw_rd1", 32'({state, mem_rden, iord}), {4'd5, 2'b11});
      tick();
      check("lw_rd2", 32'({state, mem_rden}), {4'd5, 1'b1});
      tick();
      check("lw_rd3", 32'({state, mem_rden}), {4'd5, 1'b1});
      mem_ready = 1'b1;
      tick();
      check("lw_mwb", 32'({state, regwrite, memtoreg, redges}), {4'd6, 3'b110});
      tick();
      check("lw_ret", 32'({state, instr_count}), {4'd0, 4'd2});
      // BEQ zero=1 taken, BNE zero=1 not taken
      op = 6'd4;
      zero = 1'b1;
      tick();
      tick();
      check("beq_br", 32'({state, branch, alucs, selscrB, alu_src_a}), {4'd8, 1'b1, 5'd3, 2'd0, 1'b1});
      tick();
      check("beq_ret", 32'({state, instr_count}), {4'd0, 4'd3});
      op = 6'd5;
      tick();
      tick();
      check("bne_br", 32'({state, branch}), {4'd8, 1'b0});
      zero = 1'b0;
      #1;
      check("bne_z0", 32'(branch), 1);
      tick();
      check("bne_ret", 32'({state, instr_count}), {4'd0, 4'd4});
      // Illegal opcode and illegal funct
      op = 6'd63;
      tick();
      check("ill_op", 32'({state, illegal, regwrite, mem_wren}), {4'd1, 3'b100});
      tick();
      check("ill_op_nx", 32'({state, illegal, instr_count}), {4'd0, 1'b0, 4'd4});
      op = 6'd0;
      funct = 6'd7;
      tick();
      check("ill_fn", 32'({state, illegal}), {4'd1, 1'b1});
      tick();
      check("ill_fn_nx", 32'({state, illegal, instr_count}), {4'd0, 1'b0, 4'd4});
      // ANDI
      op = 6'd12;
      tick();
      check("andi_dec", 32'({state, illegal}), {4'd1, 1'b0});
      tick();
      check("andi_ex", 32'({state, alucs, selscrB, flagwrite}), {4'd3, 5'd0, 2'd2, 1'b1});
      tick();
      check("andi_wb", 32'({state, regwrite, redges}), {4'd10, 2'b10});
      tick();
      check("andi_ret", 32'(instr_count), 5);
      // SW aborted by reset while waiting in MEMWR
      op = 6'd43;
      tick();
      tick();
      check("sw_adr", 32'(state), 4);
      mem_ready = 1'b0;
      tick();
      check("sw_wr1", 32'({state, mem_wren, iord, regwrite}), {4'd7, 3'b110});
      tick();
      check("sw_wr2", 32'({state, mem_wren}), {4'd7, 1'b1});
      rst = 1'b1;
      tick();
      check("sw_rst", 32'(all_outs), 0);
      rst = 1'b0;
      #1;
      check("sw_abort", 32'({state, mem_wren, instr_count}), {4'd0, 1'b0, 4'd0});
      // 16 jumps wrap the 4-bit counter back to 0
      op = 6'd2;
      mem_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         tick();
         if (i == 0) check("j_jump", 32'({state, jump, regwrite}), {4'd9, 2'b10});
         tick();
         if (i == 14) check("j_cnt15", 32'(instr_count), 15);
      end
      check("j_wrap", 32'({state, instr_count}), {4'd0, 4'd0});
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
